mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Responder side of the instruction-fetch request/response interface, plus the load/store port. Accepts word fetch requests from the instruction cache and byte/half/word load/store requests from the load-store buffer. Serialises them onto the byte-wide unified RAM port and returns assembled little-endian results with single-cycle done pulses. Sits between the fetch/LSB front end and the external RAM.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; cancels pending/in-flight instruction fetch.
- ic_asking  in  1  one-cycle fetch request pulse.
- ic_addr  in  32  fetch address (2-byte aligned, may be unaligned to 4).
- ic_data  out  32  fetched word, little-endian.
- ic_data_ready  out  1  one-cycle pulse, ic_data valid.
- lsb_valid  in  1  one-cycle load/store request pulse.
- lsb_wr  in  1  1 = store, 0 = load.
- lsb_addr  in  32  byte address.
- lsb_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- lsb_wdata  in  32  store data; low bytes used.
- lsb_rdata  out  32  load result, zero-extended.
- lsb_done  out  1  one-cycle pulse, load/store complete.
- mem_din  in  8  RAM read byte for the address driven in the previous cycle.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  RAM write enable.
- busy  out  1  high when state is not IDLE.

## Operation
- Request capture:
  - ic_asking latches ic_addr into ic_pend/ic_paddr; lsb_valid latches wr/addr/size/wdata into lsb_pend.
  - A new pulse while the same side is pending or in service is a protocol error; it overwrites the latch and is not checked.
- States: IDLE, READ, WRITE.
  - READ carries an owner bit (IC or LSB). A byte counter cnt (0..3) and byte count n (1, 2 or 4) are kept.
- IDLE, start of a transaction:
  - If lsb_pend is set, start the LSB transaction. LSB has priority over IC.
  - Otherwise, if ic_pend is set and flush is low, start the IC read with n=4.
  - Start clears the corresponding pend bit and sets cnt=0.
  - Store: enter WRITE and drive mem_a=addr, mem_dout=wdata[7:0], mem_wr=1.
  - Load or fetch: enter READ and drive mem_a=addr, mem_wr=0.
- READ:
  - Each cycle, capture mem_din into byte cnt of the assembly register, increment cnt, and drive mem_a=base+cnt+1 while bytes remain.
  - After byte n-1 is captured, return to IDLE. Pulse the owner's done/ready with the assembled data; upper unused bytes are 0.
- WRITE:
  - Drive byte i at mem_a=addr+i, mem_wr=1, for i=0..n-1.
  - After the last byte, drop mem_wr to 0, pulse lsb_done, and return to IDLE.
- Address arithmetic is 32-bit modulo (0xFFFFFFFF+1 wraps to 0). No alignment checks.
- flush:
  - Clears ic_pend.
  - If READ is owned by IC, abort to IDLE next edge with no ic_data_ready.
  - LSB transactions are unaffected.
  - flush coincident with ic_asking drops that request.
- rst: state=IDLE, both pend bits cleared, any transaction aborted with no done pulse.

## Timing
- Reset values: ic_data=0, ic_data_ready=0, lsb_rdata=0, lsb_done=0, mem_dout=0, mem_a=0, mem_wr=0, busy=0.
- Let E0 be the accepting edge; ic_asking/lsb_valid must have been sampled at or before E0.
- Read of n bytes:
  - Byte i is addressed after edge E0+i and captured at E0+i+1.
  - The done pulse is high for exactly the cycle after E0+n.
  - IC fetch: 4 cycles from accept to ic_data_ready; 5 from request sample if idle.
- Write of n bytes:
  - mem_wr is high for the n cycles after E0..E0+n-1.
  - lsb_done is high the cycle after E0+n.
- The earliest next accept is E0+n+1: one idle cycle between transactions.
- mem_wr is never high in READ or IDLE.
- ic_data_ready and lsb_done are never high in the same cycle.

## Test plan
- IC fetch: RAM[0x100..0x103]=13 05 A0 00, pulse ic_asking with ic_addr=0x100 -> ic_data=0x00A00513, ic_data_ready high exactly 1 cycle, 5 cycles after the request; mem_wr stays 0.
- Store then load: store word 0xDEADBEEF to 0x200 -> RAM bytes EF BE AD DE, lsb_done pulse; then load half, lsb_addr=0x202 -> lsb_rdata=0x0000DEAD.
- Simultaneous requests: ic_asking and lsb_valid (load byte) in the same cycle -> LSB served first; ic_data_ready follows after the LSB done plus one idle cycle.
- Flush mid-fetch: flush two cycles after the fetch starts -> no ic_data_ready ever; busy low next cycle; a following fetch returns correct data.
- Wrap: load word at 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset mid-write: rst during byte 1 of a word store -> mem_wr=0 next cycle, no lsb_done; all outputs match reset values.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetches and load/store requests onto
// a byte-wide unified RAM port and returns little-endian results.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   flush             - cancels pending / in-flight instruction fetch
//   ic_asking/ic_addr - fetch request pulse and address
//   ic_data/_ready    - fetched word and one-cycle ready pulse
//   lsb_valid/wr/addr/size/wdata - load/store request
//   lsb_rdata/done    - load result and one-cycle completion pulse
//   mem_din/dout/a/wr - byte-wide RAM port
//   busy              - controller not idle
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ic_asking,
    input  logic [31:0] ic_addr,
    output logic [31:0] ic_data,
    output logic        ic_data_ready,
    input  logic        lsb_valid,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_wdata,
    output logic [31:0] lsb_rdata,
    output logic        lsb_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e      state_q, state_d;
    logic        own_ic_q, own_ic_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] asm_q, asm_d;

    logic        ic_pend_q, ic_pend_d;
    logic [31:0] ic_paddr_q, ic_paddr_d;
    logic        lsb_pend_q, lsb_pend_d;
    logic        lsb_pwr_q, lsb_pwr_d;
    logic [31:0] lsb_paddr_q, lsb_paddr_d;
    logic [1:0]  lsb_psize_q, lsb_psize_d;
    logic [31:0] lsb_pwdata_q, lsb_pwdata_d;

    logic [31:0] ic_data_q, ic_data_d;
    logic        ic_rdy_q, ic_rdy_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;
    logic        lsb_done_q, lsb_done_d;
    logic [7:0]  dout_q, dout_d;
    logic [31:0] a_q, a_d;
    logic        wr_q, wr_d;

    logic        last;
    logic [1:0]  cnt_inc;
    logic [31:0] asm_new;
    logic [31:0] wshift;

    always_comb begin
        state_d      = state_q;
        own_ic_d     = own_ic_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        base_d       = base_q;
        wbuf_d       = wbuf_q;
        asm_d        = asm_q;
        ic_pend_d    = ic_pend_q;
        ic_paddr_d   = ic_paddr_q;
        lsb_pend_d   = lsb_pend_q;
        lsb_pwr_d    = lsb_pwr_q;
        lsb_paddr_d  = lsb_paddr_q;
        lsb_psize_d  = lsb_psize_q;
        lsb_pwdata_d = lsb_pwdata_q;
        ic_data_d    = ic_data_q;
        ic_rdy_d     = 1'b0;
        lsb_rdata_d  = lsb_rdata_q;
        lsb_done_d   = 1'b0;
        dout_d       = dout_q;
        a_d          = a_q;
        wr_d         = 1'b0;

        last    = ({1'b0, cnt_q} == (n_q - 3'd1));
        cnt_inc = cnt_q + 2'd1;
        asm_new = asm_q;
        asm_new[{cnt_q, 3'b000} +: 8] = mem_din;
        wshift  = wbuf_q >> {cnt_inc, 3'b000};

        unique case (state_q)
            IDLE: begin
                // LSB wins over IC when both are pending
                if (lsb_pend_q) begin
                    lsb_pend_d = 1'b0;
                    own_ic_d   = 1'b0;
                    cnt_d      = 2'd0;
                    base_d     = lsb_paddr_q;
                    wbuf_d     = lsb_pwdata_q;
                    asm_d      = 32'd0;
                    a_d        = lsb_paddr_q;
                    n_d        = (lsb_psize_q == 2'b00) ? 3'd1 :
                                 (lsb_psize_q == 2'b01) ? 3'd2 : 3'd4;
                    if (lsb_pwr_q) begin
                        state_d = WRITE;
                        wr_d    = 1'b1;
                        dout_d  = lsb_pwdata_q[7:0];
                    end else begin
                        state_d = READ;
                    end
                end else if (ic_pend_q && !flush) begin
                    ic_pend_d = 1'b0;
                    own_ic_d  = 1'b1;
                    cnt_d     = 2'd0;
                    n_d       = 3'd4;
                    base_d    = ic_paddr_q;
                    asm_d     = 32'd0;
                    a_d       = ic_paddr_q;
                    state_d   = READ;
                end
            end
            READ: begin
                if (own_ic_q && flush) begin
                    state_d = IDLE;
                end else begin
                    asm_d = asm_new;
                    if (last) begin
                        state_d = IDLE;
                        if (own_ic_q) begin
                            ic_data_d = asm_new;
                            ic_rdy_d  = 1'b1;
                        end else begin
                            lsb_rdata_d = asm_new;
                            lsb_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        a_d   = base_q + {30'd0, cnt_inc};
                    end
                end
            end
            WRITE: begin
                if (last) begin
                    state_d    = IDLE;
                    lsb_done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_inc;
                    a_d    = base_q + {30'd0, cnt_inc};
                    dout_d = wshift[7:0];
                    wr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // capture after start so a back-to-back pulse is not lost
        if (ic_asking) begin
            ic_pend_d  = 1'b1;
            ic_paddr_d = ic_addr;
        end
        if (flush) ic_pend_d = 1'b0;
        if (lsb_valid) begin
            lsb_pend_d   = 1'b1;
            lsb_pwr_d    = lsb_wr;
            lsb_paddr_d  = lsb_addr;
            lsb_psize_d  = lsb_size;
            lsb_pwdata_d = lsb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            own_ic_q     <= 1'b0;
            cnt_q        <= 2'd0;
            n_q          <= 3'd1;
            base_q       <= 32'd0;
            wbuf_q       <= 32'd0;
            asm_q        <= 32'd0;
            ic_pend_q    <= 1'b0;
            ic_paddr_q   <= 32'd0;
            lsb_pend_q   <= 1'b0;
            lsb_pwr_q    <= 1'b0;
            lsb_paddr_q  <= 32'd0;
            lsb_psize_q  <= 2'd0;
            lsb_pwdata_q <= 32'd0;
            ic_data_q    <= 32'd0;
            ic_rdy_q     <= 1'b0;
            lsb_rdata_q  <= 32'd0;
            lsb_done_q   <= 1'b0;
            dout_q       <= 8'd0;
            a_q          <= 32'd0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_ic_q     <= own_ic_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            base_q       <= base_d;
            wbuf_q       <= wbuf_d;
            asm_q        <= asm_d;
            ic_pend_q    <= ic_pend_d;
            ic_paddr_q   <= ic_paddr_d;
            lsb_pend_q   <= lsb_pend_d;
            lsb_pwr_q    <= lsb_pwr_d;
            lsb_paddr_q  <= lsb_paddr_d;
            lsb_psize_q  <= lsb_psize_d;
            lsb_pwdata_q <= lsb_pwdata_d;
            ic_data_q    <= ic_data_d;
            ic_rdy_q     <= ic_rdy_d;
            lsb_rdata_q  <= lsb_rdata_d;
            lsb_done_q   <= lsb_done_d;
            dout_q       <= dout_d;
            a_q          <= a_d;
            wr_q         <= wr_d;
        end
    end

    assign ic_data       = ic_data_q;
    assign ic_data_ready = ic_rdy_q;
    assign lsb_rdata     = lsb_rdata_q;
    assign lsb_done      = lsb_done_q;
    assign mem_dout      = dout_q;
    assign mem_a         = a_q;
    assign mem_wr        = wr_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven and scoreboard bench for mem_ctrl
// with a combinational-read byte RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ic_asking = 1'b0;
    logic [31:0] ic_addr = 32'd0;
    logic [31:0] ic_data;
    logic        ic_data_ready;
    logic        lsb_valid = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [1:0]  lsb_size = 2'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic [31:0] lsb_rdata;
    logic        lsb_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ic_asking(ic_asking), .ic_addr(ic_addr),
        .ic_data(ic_data), .ic_data_ready(ic_data_ready),
        .lsb_valid(lsb_valid), .lsb_wr(lsb_wr),
        .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata),
        .lsb_done(lsb_done), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .busy(busy)
    );

    logic [7:0] ram [4096];
    always @(posedge clk) if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    assign mem_din = ram[mem_a[11:0]];

    typedef struct {
        logic        ld;
        logic [31:0] d;
    } sb_t;
    sb_t         lsb_sb[$];
    logic [31:0] ic_sb[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bad(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("excl_pulse", {31'd0, ic_data_ready & lsb_done}, 32'd0);
            if (mem_wr) chk("wr_busy", {31'd0, busy}, 32'd1);
            if (ic_data_ready) begin
                if (ic_sb.size() == 0) bad("unexpected ic_data_ready");
                else chk("ic_data", ic_data, ic_sb.pop_front());
            end
            if (lsb_done) begin
                if (lsb_sb.size() == 0) bad("unexpected lsb_done");
                else begin
                    sb_t e;
                    e = lsb_sb.pop_front();
                    if (e.ld) chk("lsb_rdata", lsb_rdata, e.d);
                end
            end
        end
    end

    // one-cycle request pulse: returns just after the sampling edge
    task automatic pulse(input logic ic, input logic [31:0] ia,
                         input logic lv, input logic w,
                         input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] wd, input logic fl);
        @(posedge clk);
        #1;
        ic_asking = ic;
        ic_addr   = ia;
        lsb_valid = lv;
        lsb_wr    = w;
        lsb_addr  = a;
        lsb_size  = s;
        lsb_wdata = wd;
        flush     = fl;
        @(posedge clk);
        #1;
        ic_asking = 1'b0;
        lsb_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ic_sb.size() == 0 && lsb_sb.size() == 0 && !busy)
                return;
        end
        bad({nm, " timeout"});
        ic_sb.delete();
        lsb_sb.delete();
    endtask

    task automatic lsb_op(input logic w, input logic [31:0] a,
                          input logic [1:0] s, input logic [31:0] wd,
                          input logic [31:0] exp);
        sb_t e;
        e.ld = !w;
        e.d  = exp;
        lsb_sb.push_back(e);
        pulse(1'b0, 32'd0, 1'b1, w, a, s, wd, 1'b0);
        wait_idle("lsb_op");
    endtask

    task automatic chk_reset_vals(string p);
        chk({p, "_ic_data"}, ic_data, 32'd0);
        chk({p, "_ic_rdy"}, {31'd0, ic_data_ready}, 32'd0);
        chk({p, "_lsb_rdata"}, lsb_rdata, 32'd0);
        chk({p, "_lsb_done"}, {31'd0, lsb_done}, 32'd0);
        chk({p, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
        chk({p, "_mem_a"}, mem_a, 32'd0);
        chk({p, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({p, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] wrap_a [4];

    initial begin
        tbl[0]  = '{1'b1, 32'h200, 2'd2, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 32'h202, 2'd1, 32'h0, 32'h0000DEAD};
        tbl[2]  = '{1'b0, 32'h201, 2'd0, 32'h0, 32'h000000BE};
        tbl[3]  = '{1'b0, 32'h200, 2'd2, 32'h0, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 32'h204, 2'd2, 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 32'h204, 2'd0, 32'h12345678, 32'h0};
        tbl[6]  = '{1'b1, 32'h206, 2'd1, 32'hAAAACAFE, 32'h0};
        tbl[7]  = '{1'b0, 32'h204, 2'd2, 32'h0, 32'hCAFE0078};
        tbl[8]  = '{1'b0, 32'h205, 2'd1, 32'h0, 32'h0000FE00};
        tbl[9]  = '{1'b0, 32'h207, 2'd0, 32'h0, 32'h000000CA};
        tbl[10] = '{1'b0, 32'h200, 2'd3, 32'h0, 32'hDEADBEEF};
        wrap_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;

        // table of loads and stores
        for (int i = 0; i < 11; i++) begin
            lsb_op(tbl[i].wr, tbl[i].addr, tbl[i].size,
                   tbl[i].wdata, tbl[i].exp);
            if (i == 0) begin
                chk("ram200", {24'd0, ram[12'h200]}, 32'hEF);
                chk("ram201", {24'd0, ram[12'h201]}, 32'hBE);
                chk("ram202", {24'd0, ram[12'h202]}, 32'hAD);
                chk("ram203", {24'd0, ram[12'h203]}, 32'hDE);
            end
        end

        // fetch: ready exactly in cycle 5 after the request sample
        lsb_op(1'b1, 32'h100, 2'd2, 32'h00A00513, 32'h0);
        chk("ram100", {24'd0, ram[12'h100]}, 32'h13);
        chk("ram103", {24'd0, ram[12'h103]}, 32'h00);
        ic_sb.push_back(32'h00A00513);
        pulse(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("fetch_rdy_k%0d", k),
                {31'd0, ic_data_ready}, {31'd0, k == 6});
            chk("fetch_wr0", {31'd0, mem_wr}, 32'd0);
        end
        wait_idle("fetch");

        // simultaneous requests: LSB first, then IC after idle cycle
        begin
            sb_t e;
            e.ld = 1'b1;
            e.d  = 32'h000000DE;
            lsb_sb.push_back(e);
        end
        ic_sb.push_back(32'h00A00513);
        pulse(1'b1, 32'h100, 1'b1, 1'b0, 32'h203, 2'd0, 32'h0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("sim_done_k%0d", k),
                {31'd0, lsb_done}, {31'd0, k == 3});
            chk($sformatf("sim_rdy_k%0d", k),
                {31'd0, ic_data_ready}, {31'd0, k == 8});
        end
        wait_idle("simul");

        // flush two cycles into a fetch
        pulse(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("flush_no_rdy", {31'd0, ic_data_ready}, 32'd0);
        end
        ic_sb.push_back(32'h00A00513);
        pulse(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
        wait_idle("refetch");

        // flush coincident with the request drops it
        pulse(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("flush_drop_busy", {31'd0, busy}, 32'd0);
        end

        // address wrap
        lsb_op(1'b1, 32'hFFFFFFFE, 2'd2, 32'h44332211, 32'h0);
        chk("ram000", {24'd0, ram[12'h000]}, 32'h33);
        begin
            sb_t e;
            e.ld = 1'b1;
            e.d  = 32'h44332211;
            lsb_sb.push_back(e);
        end
        pulse(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFE, 2'd2, 32'h0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k >= 2)
                chk($sformatf("wrap_a%0d", k - 2), mem_a, wrap_a[k - 2]);
        end
        wait_idle("wrap");

        // reset during byte 1 of a word store
        pulse(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 2'd2, 32'h55667788, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rw_a0", mem_a, 32'h300);
        chk("rw_wr0", {31'd0, mem_wr}, 32'd1);
        @(negedge clk);
        chk("rw_a1", mem_a, 32'h301);
        chk("rw_d1", {24'd0, mem_dout}, 32'h77);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, lsb_done}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
